snitch_icache_refill_beats: RTL

// Refill stage downstream of the icache miss handler. Accepts line-refill requests (line addr + pending-table id),

---
 rtl/snitch_icache_refill_beats.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/snitch_icache_refill_beats.sv
// Refill stage: forwards line-refill requests as single bursts on a narrow
// memory port, tracks request ids in an in-order FIFO, assembles the returned
// beats into one cache line and hands it back with its id and an error flag.
module snitch_icache_refill_beats #(
  parameter int unsigned FETCH_AW        = 48,
  parameter int unsigned LINE_WIDTH      = 128,
  parameter int unsigned PENDING_IW      = 2,
  parameter int unsigned MEM_AW          = 48,
  parameter int unsigned MEM_DW          = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [FETCH_AW-1:0]   in_req_addr_i,
  input  logic [PENDING_IW-1:0] in_req_id_i,
  input  logic                  in_req_valid_i,
  output logic                  in_req_ready_o,
  output logic [MEM_AW-1:0]     mem_req_addr_o,
  output logic [7:0]            mem_req_len_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  input  logic [MEM_DW-1:0]     mem_rsp_data_i,
  input  logic                  mem_rsp_error_i,
  input  logic                  mem_rsp_last_i,
  input  logic                  mem_rsp_valid_i,
  output logic                  mem_rsp_ready_o,
  output logic [LINE_WIDTH-1:0] out_rsp_data_o,
  output logic                  out_rsp_error_o,
  output logic [PENDING_IW-1:0] out_rsp_id_o,
  output logic                  out_rsp_valid_o,
  input  logic                  out_rsp_ready_i
);

  localparam int unsigned BEATS      = LINE_WIDTH / MEM_DW;
  localparam int unsigned LINE_ALIGN = $clog2(LINE_WIDTH / 8);
  localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned FILL_W     = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {COLLECT, HOLD} state_e;

  state_e                state_reg, state_next;
  logic [CNT_W-1:0]      beat_cnt_reg;
  logic                  err_acc_reg;
  logic [PENDING_IW-1:0] out_id_reg;
  logic                  out_err_reg;

  logic [PENDING_IW-1:0] id_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [FILL_W-1:0]     fill_reg;
  logic                  fifo_full, fifo_empty, push, pop;

  logic                  beat_fire, line_done, final_beat, beat_err;
  logic [FETCH_AW-1:0]   line_addr;
  logic                  unused_addr_bits;

  // ---------------------------------------------------------------------------
  // Request path: purely combinational, the id FIFO only gates it when full.
  // A pop in the same cycle does not free a slot for the push (no bypass).
  // ---------------------------------------------------------------------------
  assign line_addr        = {in_req_addr_i[FETCH_AW-1:LINE_ALIGN], {LINE_ALIGN{1'b0}}};
  assign unused_addr_bits = ^in_req_addr_i[LINE_ALIGN-1:0];
  assign mem_req_addr_o   = MEM_AW'(line_addr);
  assign mem_req_len_o    = 8'(BEATS - 1);
  assign mem_req_valid_o  = in_req_valid_i && !fifo_full;
  assign in_req_ready_o   = mem_req_ready_i && !fifo_full;

  assign fifo_full  = (fill_reg == FILL_W'(MAX_OUTSTANDING));
  assign fifo_empty = (fill_reg == '0);
  assign push       = in_req_valid_i && in_req_ready_o;
  assign pop        = line_done;

  // Id storage, RAM style: no reset, written on every accepted request.
  always_ff @(posedge clk_i) begin
    if (push) id_mem[wr_ptr_reg] <= in_req_id_i;
  end

  // FIFO pointers and fill level; depth need not be a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= (wr_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_reg + 1'b1;
      fill_reg <= fill_reg + FILL_W'(push) - FILL_W'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Response path. The beat counter decides where a line ends; the last flag
  // is only cross-checked and folds into the error on disagreement.
  // ---------------------------------------------------------------------------
  assign final_beat = (beat_cnt_reg == CNT_W'(BEATS - 1));
  assign beat_err   = mem_rsp_error_i | (mem_rsp_last_i != final_beat);

  // Next-state and handshake decode for the COLLECT / HOLD machine.
  always_comb begin
    state_next      = state_reg;
    mem_rsp_ready_o = 1'b0;
    beat_fire       = 1'b0;
    line_done       = 1'b0;
    case (state_reg)
      COLLECT: begin
        mem_rsp_ready_o = !fifo_empty;
        beat_fire       = mem_rsp_valid_i && !fifo_empty;
        line_done       = beat_fire && final_beat;
        if (line_done) state_next = HOLD;
      end
      HOLD: begin
        if (out_rsp_ready_i) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= COLLECT;
    else       state_reg <= state_next;
  end

  // Beat counter and error accumulator, both cleared when a line completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt_reg <= '0;
      err_acc_reg  <= 1'b0;
    end else if (beat_fire) begin
      if (line_done) begin
        beat_cnt_reg <= '0;
        err_acc_reg  <= 1'b0;
      end else begin
        beat_cnt_reg <= beat_cnt_reg + 1'b1;
        err_acc_reg  <= err_acc_reg | beat_err;
      end
    end
  end

  // Capture id (FIFO head) and final error as the line completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_id_reg  <= '0;
      out_err_reg <= 1'b0;
    end else if (line_done) begin
      out_id_reg  <= id_mem[rd_ptr_reg];
      out_err_reg <= err_acc_reg | beat_err;
    end
  end

  // One register per beat slot; no writes happen in HOLD so the line is stable.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
    logic [MEM_DW-1:0] slot_reg;

    // Slot gi takes the beat whose counter value equals gi.
    always_ff @(posedge clk_i) begin
      if (rst_i)                                              slot_reg <= '0;
      else if (beat_fire && (beat_cnt_reg == CNT_W'(gi)))     slot_reg <= mem_rsp_data_i;
    end

    assign out_rsp_data_o[gi*MEM_DW +: MEM_DW] = slot_reg;
  end

  assign out_rsp_valid_o = (state_reg == HOLD);
  assign out_rsp_id_o    = out_id_reg;
  assign out_rsp_error_o = out_err_reg;

  // A beat offered while no burst is outstanding cannot belong to anything.
  a_beat_without_burst: assert property (@(posedge clk_i) disable iff (rst_i)
    !(mem_rsp_valid_i && fifo_empty));

endmodule
